// File: rtl/alu_pkg.sv
// Shared definitions for ALU front-ends: opcodes, issue FSM states and the
// opcode-to-strobe decode.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } issue_state_t;

    // Strobe vector ordering is {div, mul, sub, add}.
    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        logic [3:0] strobes;
        strobes = 4'b0000;
        strobes[op] = 1'b1;
        return strobes;
    endfunction

endpackage

// File: rtl/alu_settle_counter.sv
// Loadable 8-bit down-counter that times how long an ALU strobe is held.
module alu_settle_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       enable,
    output logic       zero
);

    logic [7:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else if (load) begin
            count_q <= load_value;
        end else if (enable && (count_q != 8'd0)) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign zero = (count_q == 8'd0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the ALU: accepts one op, holds a one-hot strobe
// for the op's settle time, captures the answer and presents it until consumed.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a request; strobes low
// ST_EXEC | operands and one strobe held while the ALU settles
// ST_DONE | result held on the response port until rsp_ready
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADD_CYCLES = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_add,
    output logic             alu_sub,
    output logic             alu_mul,
    output logic             alu_div,
    input  logic [WIDTH-1:0] alu_answer,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_op,
    output logic             rsp_err,
    output logic             busy
);

    localparam logic [7:0] ADD_LOAD = 8'(ADD_CYCLES - 1);
    localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    issue_state_t state_q, state_d;
    logic [3:0]   strobes_q;
    logic         accept;
    logic         div_zero;
    logic         capture;
    logic         cnt_zero;
    logic [7:0]   cnt_load_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        div_zero = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if ((req_op == OP_DIV) && (req_b == '0)) begin
                        div_zero = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_zero) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_load_value = ADD_LOAD;
        case (req_op)
            OP_MUL:  cnt_load_value = MUL_LOAD;
            OP_DIV:  cnt_load_value = DIV_LOAD;
            default: cnt_load_value = ADD_LOAD;
        endcase
    end

    alu_settle_counter u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept && !div_zero),
        .load_value (cnt_load_value),
        .enable     (state_q == ST_EXEC),
        .zero       (cnt_zero)
    );

    // Divide-by-zero never reaches the ALU: the saturated result is written here directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_data  <= '0;
            rsp_op    <= OP_ADD;
            rsp_err   <= 1'b0;
            strobes_q <= 4'b0000;
        end else if (accept) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            rsp_op  <= req_op;
            rsp_err <= div_zero;
            if (div_zero) begin
                rsp_data  <= '1;
                strobes_q <= 4'b0000;
            end else begin
                strobes_q <= op_onehot(req_op);
            end
        end else if (capture) begin
            rsp_data  <= alu_answer;
            strobes_q <= 4'b0000;
        end
    end

    assign {alu_div, alu_mul, alu_sub, alu_add} = strobes_q;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing stage directly upstream of the ALU interface (A/B operands, one-hot Add/Sub/Mul/Div strobes, 32-bit Answer).
- Accepts one operation request per valid/ready handshake and registers the operands.
- Drives a stable one-hot strobe for an op-dependent number of settle cycles, captures Answer, and holds the result on a valid/ready response port until it is consumed.

Parameters:
- WIDTH, 32, operand/result width.
- ADD_CYCLES, 1, settle cycles for add/sub; legal range 1..255.
- MUL_CYCLES, 2, settle cycles for mul; legal range 1..255.
- DIV_CYCLES, 4, settle cycles for div; legal range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- alu_a  out  WIDTH  registered operand A to the ALU.
- alu_b  out  WIDTH  registered operand B to the ALU.
- alu_add / alu_sub / alu_mul / alu_div  out  1 each  one-hot op strobes.
- alu_answer  in  WIDTH  ALU result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  WIDTH  captured result.
- rsp_op  out  2  opcode of the result.
- rsp_err  out  1  divide-by-zero flag.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE; alu_a, alu_b, rsp_data=0; all strobes=0; rsp_valid, rsp_err=0; rsp_op=00; counter=0. Release is sampled synchronously on the next edge.
- req_ready = (state==IDLE), purely decoded from state. No request is accepted in EXEC or DONE.
- IDLE: on an edge with req_valid=1:
  - Latch req_a, req_b into alu_a, alu_b; latch req_op into rsp_op.
  - Clear rsp_err.
  - If req_op=11 and req_b==0: rsp_data={WIDTH{1'b1}}, rsp_err=1, strobes stay 0, go DONE (no ALU cycles).
  - Otherwise: set exactly one strobe per req_op, load counter=N-1 (N per op class), go EXEC.
- EXEC: strobe and operands held constant.
  - counter!=0: decrement.
  - counter==0: rsp_data<=alu_answer, all strobes cleared, go DONE.
- DONE: rsp_valid=1; rsp_data, rsp_op, rsp_err held stable. On an edge with rsp_ready=1 go IDLE, rsp_valid<=0.
- Latency: accept edge E0 → capture at edge E0+N → rsp_valid high in the cycle after E0+N. The div-by-zero path gives rsp_valid in the cycle after E0.
- Throughput: one op per N+2 cycles minimum, including the mandatory IDLE bubble after DONE.
- At most one strobe is high in any cycle. Strobes are 0 in IDLE and DONE.
- req_valid is ignored outside IDLE, including while rsp_ready=1 in DONE. Request fields are don't-care when not accepted.
- Reset asserted mid-EXEC or mid-DONE: immediate return to reset values; the in-flight op is discarded with no response.
- Counter width is 8 bits. Width is purely arithmetic; no sign handling, since signedness belongs to the ALU.
- rsp_data on the normal path is an unmodified WIDTH-bit copy of alu_answer.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - FSM state encoding ST_IDLE, ST_EXEC, ST_DONE.
  - The opcode→one-hot decode function, reused by other ALU front-ends.
- One natural sub-module: alu_settle_counter. It is a loadable 8-bit down-counter with load, load_value and a zero flag. The FSM stays in alu_issue_ctrl.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release → req_ready=1, rsp_valid=0, all strobes 0, busy=0.
- Add: req_op=00, A=6, B=5, ALU model combinational, rsp_ready=1 → alu_add=1 for exactly 1 cycle; rsp_valid in the cycle after E0+1; rsp_data=11, rsp_op=00, rsp_err=0; back to IDLE next edge.
- Mul latency: MUL_CYCLES=2, A=6, B=5, rsp_ready held 0 for 5 cycles → alu_mul high for 2 cycles; rsp_valid rises after E0+2 and holds rsp_data=30 stable; req_valid pulses are ignored while stalled; IDLE one edge after rsp_ready=1.
- Div by zero: req_op=11, A=7, B=0 → no strobe ever asserted; rsp_valid in the cycle after E0; rsp_data=0xFFFFFFFF, rsp_err=1. A following div 7/2 (DIV_CYCLES=4) returns 3 with rsp_err=0.
- Reset mid-op: DIV_CYCLES=4, start div 100/5, assert rst_n=0 at E0+2 → strobes and busy drop asynchronously; no rsp_valid after release; next sub 9-4 returns 5.
- Back-to-back: four ops (add, sub, mul, div) with req_valid held 1 and rsp_ready=1 → each accepted only in IDLE; one-hot strobes checked every cycle; results 11, 1, 30, 1 for A=6, B=5.
